param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_pkg.sv | 11 +
 rtl/param_fifo_mem.sv | 21 ++
 rtl/param_fifo.sv | 144 ++++++++++++++
 tb/tb_param_fifo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared defaults and the occupancy-counter width helper for param_fifo.
package param_fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_MARGIN = 4;

    // count must represent 0..depth inclusive, hence the extra bit
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/param_fifo_mem.sv
// Simple dual-port storage for param_fifo: synchronous write, registered read, no reset.
module param_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // a same-address read and write in one cycle returns the old word
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/param_fifo.sv
// Parameterized synchronous FIFO with registered flags and sticky error flags.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through output; default is standard mode.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - DEF_MARGIN,
    parameter int AE_LVL = DEF_MARGIN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         din,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         dout,
    output logic                      dout_vld,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    input  logic                      clr_err,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic [DATA_W-1:0] mem_q;
    logic              rd_acc, wr_acc, mem_we, mem_re, vld_nxt, has_data;
    logic              ov_evt, un_evt;

    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);
    assign ov_evt = wr_en && full && !rd_acc;
    // a write in the same cycle fills the FIFO, so the read is not an underflow
    assign un_evt = rd_en && empty && !wr_en;

`ifdef PARAM_FIFO_FWFT_EN
    logic [CW-1:0]     mem_cnt;
    logic [DATA_W-1:0] byp_q;
    logic              byp_ld, src_byp;

    // the output register holds one word, so storage holds count minus that word
    assign mem_cnt = count - CW'(dout_vld);

    always_comb begin
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        byp_ld  = 1'b0;
        vld_nxt = 1'b0;
        if (!dout_vld || rd_acc) begin
            if (mem_cnt != '0) begin
                mem_re  = 1'b1;
                mem_we  = wr_acc;
                vld_nxt = 1'b1;
            end else if (wr_acc) begin
                byp_ld  = 1'b1;
                vld_nxt = 1'b1;
            end
        end else begin
            mem_we  = wr_acc;
            vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) src_byp <= 1'b0;
        else if (mem_re || byp_ld) src_byp <= byp_ld;
    end

    always_ff @(posedge clk) begin
        if (byp_ld) byp_q <= din;
    end

    assign dout = !has_data ? '0 : (src_byp ? byp_q : mem_q);
`else
    always_comb begin
        mem_we  = wr_acc;
        mem_re  = rd_acc;
        vld_nxt = rd_acc;
    end

    assign dout = has_data ? mem_q : '0;
`endif

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // flags come from count_nxt so they line up with count, not a cycle behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            dout_vld     <= 1'b0;
            has_data     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (mem_we) wr_ptr <= wr_ptr + 1'b1;
            if (mem_re) rd_ptr <= rd_ptr + 1'b1;
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LVL));
            almost_empty <= (count_nxt <= CW'(AE_LVL));
            dout_vld     <= vld_nxt;
`ifdef PARAM_FIFO_FWFT_EN
            if (mem_re || byp_ld) has_data <= 1'b1;
`else
            if (mem_re) has_data <= 1'b1;
`endif
            overflow     <= ov_evt || (overflow && !clr_err);
            underflow    <= un_evt || (underflow && !clr_err);
        end
    end

    param_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (mem_re),
        .rd_addr (rd_ptr),
        .rd_data (mem_q)
    );
endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed scenarios plus random traffic vs a queue model.
module tb_param_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int AF_LVL = 60;
    localparam int AE_LVL = 4;
    localparam int CW     = 7;

    logic              clk = 1'b0;
    logic              rst, wr_en, rd_en, clr_err;
    logic [DATA_W-1:0] din, dout;
    logic              dout_vld, full, empty, almost_full, almost_empty;
    logic [CW-1:0]     count;
    logic              overflow, underflow;

    param_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout;
    logic              m_vld, m_ov, m_un;
    int                n_chk, n_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", 32'(count), n);
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AF_LVL));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE_LVL));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
`ifdef PARAM_FIFO_FWFT_EN
        chk("dout_vld", 32'(dout_vld), 32'(n > 0));
        if (n > 0) chk("dout", 32'(dout), 32'(q[0]));
`else
        chk("dout_vld", 32'(dout_vld), 32'(m_vld));
        chk("dout", 32'(dout), 32'(m_dout));
`endif
    endtask

    // queue model: a read frees room for a same-cycle write; empty+write is write-only
    task automatic model(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
        int n;
        bit rd_ok, wr_ok;
        n     = q.size();
        rd_ok = r && (n > 0);
        wr_ok = w && ((n < DEPTH) || rd_ok);
        m_vld = 1'b0;
        if (rd_ok) begin
            m_dout = q.pop_front();
            m_vld  = 1'b1;
        end
        if (wr_ok) q.push_back(d);
        if (w && n == DEPTH && !rd_ok) m_ov = 1'b1;
        else if (c) m_ov = 1'b0;
        if (r && n == 0 && !w) m_un = 1'b1;
        else if (c) m_un = 1'b0;
    endtask

    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
        wr_en   = w;
        din     = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        #1;
        model(w, d, r, c);
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        repeat (3) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0);
        step(1, 8'hEE, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 1);

        step(1, 8'hAA, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
        chk("last_drained", 32'(m_dout), 32'h000000AA);

        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        step(1, 8'h5C, 1, 0);

        for (int i = 0; i < DEPTH && q.size() < AF_LVL; i++) step(1, 8'($urandom), 0, 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'($urandom), 0, 0);
        for (int i = 0; i < DEPTH && q.size() > AE_LVL; i++) step(0, 8'h00, 1, 0);

        repeat (200) step(1, 8'($urandom), 1, 0);

        // asynchronous reset between clock edges with data in flight
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
        step(1, 8'h01, 1, 0);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
        step(1, 8'h99, 0, 0);
        step(0, 8'h00, 1, 0);

        for (int p = 0; p < 3; p++) begin
            int pw;
            pw = (p == 0) ? 75 : ((p == 1) ? 25 : 50);
            repeat (400)
                step($urandom_range(99) < pw, 8'($urandom),
                     $urandom_range(99) < (100 - pw), $urandom_range(99) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
